// File: rtl/alu_wb_stage.sv
// alu_wb_stage: execute->writeback skid FIFO between the ALU and the register file.
// Holds {alu, z, v, n, rc, we} entries with valid/ready on both sides. It keeps the
// architectural ZVN flag register and a count of retired results.
// Optional feature: define ALU_WB_FWD_EN to add head-entry operand forwarding
// outputs (fwd_valid, fwd_rc, fwd_data) for the decode stage.
module alu_wb_stage #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu,
  input  logic        ex_z,
  input  logic        ex_v,
  input  logic        ex_n,
  input  logic [4:0]  ex_rc,
  input  logic        ex_we,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rc,
  output logic        wb_we,
  output logic [2:0]  flags_zvn,
  output logic [31:0] retire_cnt
`ifdef ALU_WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rc,
  output logic [31:0] fwd_data
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] alu;
    logic        z;
    logic        v;
    logic        n;
    logic [4:0]  rc;
    logic        we;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      flags_q, flags_d;
  logic [31:0]     retire_cnt_q, retire_cnt_d;
  logic            push, pop;
  entry_t          head;
  entry_t          in_entry;

  // Handshakes depend only on registered occupancy, so no input reaches an output combinationally.
  assign ex_ready = (count_q != CW'(DEPTH));
  assign wb_valid = (count_q != '0);
  assign push     = ex_valid && ex_ready;
  assign pop      = wb_valid && wb_ready;

  assign head     = mem_q[rd_ptr_q];
  assign in_entry = '{alu: ex_alu, z: ex_z, v: ex_v, n: ex_n, rc: ex_rc, we: ex_we};

  assign wb_data    = head.alu;
  assign wb_rc      = head.rc;
  assign wb_we      = head.we && (head.rc != 5'(ZERO_REG));
  assign flags_zvn  = flags_q;
  assign retire_cnt = retire_cnt_q;

`ifdef ALU_WB_FWD_EN
  assign fwd_valid = wb_valid && wb_we;
  assign fwd_rc    = wb_rc;
  assign fwd_data  = wb_data;
`endif

  // Next-state for pointers, occupancy, flags and retire counter.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    flags_d      = flags_q;
    retire_cnt_d = retire_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PW'(1);
      flags_d      = {head.z, head.v, head.n};
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous reset; buffered payload is left untouched by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      flags_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      flags_q      <= flags_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Payload storage, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

endmodule
